// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NUM_REQ
// requesters. One operation in flight. Operands and result are registered.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_op1/req_op2/req_ctrl
//   (request channel, packed per requester); rsp_valid/rsp_ready/rsp_result/rsp_zero
//   (response channel); alu_integer1/alu_integer2/alu_ctrl/alu_result/alu_zero (ALU);
//   busy, grant_id, grant_count (status).
// Optional macro ALU_ARB_STATS_EN builds saturating per-requester accept counters.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1,
    input  logic [NUM_REQ*DATA_W-1:0] req_op2,
    input  logic [NUM_REQ*4-1:0]      req_ctrl,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic [DATA_W-1:0]         alu_integer1,
    output logic [DATA_W-1:0]         alu_integer2,
    output logic [3:0]                alu_ctrl,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero,
    output logic                      busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [NUM_REQ*16-1:0]     grant_count
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    grant_q;
    logic [IDW-1:0]    winner;
    logic [IDW:0]      idx;
    logic              found;
    logic              handshake;
    logic              accept;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [3:0]        ctrl_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;

    // Round-robin search starting at rr_ptr, wrapping without a modulo.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ)) begin
                idx = idx - (IDW+1)'(NUM_REQ);
            end
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    // A completing response frees the ALU in the same cycle, so RESP can re-arbitrate.
    assign handshake = (state == RESP) && rsp_ready[grant_q];
    assign accept    = ((state == IDLE) || handshake) && found;

    assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
    assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << grant_q) : '0;

    assign busy       = (state != IDLE);
    assign grant_id   = grant_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (handshake) begin
                    state_next = found ? EXEC : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The ALU sees NO_ALU and zero operands except during the single EXEC cycle.
    always_comb begin
        alu_integer1 = '0;
        alu_integer2 = '0;
        alu_ctrl     = 4'b1111;
        if (state == EXEC) begin
            alu_integer1 = op1_q;
            alu_integer2 = op2_q;
            alu_ctrl     = ctrl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            grant_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            ctrl_q  <= 4'b1111;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            if (accept) begin
                op1_q   <= req_op1[winner*DATA_W +: DATA_W];
                op2_q   <= req_op2[winner*DATA_W +: DATA_W];
                ctrl_q  <= req_ctrl[winner*4 +: 4];
                grant_q <= winner;
                rr_ptr  <= (winner == IDW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
            end else if (handshake) begin
                grant_q <= '0;
            end
            if (state == EXEC) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q[winner] != 16'hFFFF)) begin
            cnt_q[winner] <= cnt_q[winner] + 16'd1;
        end
    end

    assign grant_count = cnt_q;
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter
// against a transaction-level reference model; includes a behavioural ALU.
module tb_alu_share_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*W-1:0] req_op1;
    logic [N*W-1:0] req_op2;
    logic [N*4-1:0] req_ctrl;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_zero;
    logic [W-1:0]  alu_integer1;
    logic [W-1:0]  alu_integer2;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  alu_result;
    logic          alu_zero;
    logic          busy;
    logic [0:0]    grant_id;
    logic [N*16-1:0] grant_count;

    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .req_ctrl     (req_ctrl),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .alu_integer1 (alu_integer1),
        .alu_integer2 (alu_integer2),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .busy         (busy),
        .grant_id     (grant_id),
        .grant_count  (grant_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU,
    // 7 SLL, 8 SRL, 9 SRA; anything else returns 0.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return {31'd0, $signed(a) < $signed(b)};
            4'd6: return {31'd0, a < b};
            4'd7: return a << b[4:0];
            4'd8: return a >> b[4:0];
            4'd9: return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_integer1, alu_integer2, alu_ctrl);
    assign alu_zero   = (alu_result == 32'd0);

    int vectors = 0;
    int miscompares = 0;

    // Reference model: owner of the operation in flight (-1 none), cycles since accept,
    // round-robin pointer, captured request and expected result, accept counts.
    int owner;
    int age;
    int ptr;
    int acc_w;
    int cnt[N];
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [3:0]  m_ctrl;
    logic [31:0] m_res;
    int dut_grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        owner = -1;
        age   = 0;
        ptr   = 0;
        acc_w = -1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
        req_valid[i]          = 1'b1;
        req_op1[i*32 +: 32]   = a;
        req_op2[i*32 +: 32]   = b;
        req_ctrl[i*4 +: 4]    = c;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; checks, then advances one clock.
    task automatic cycle();
        logic [N-1:0] exp_rv;
        logic [N-1:0] exp_rr;
        logic [31:0]  exp_gc;
        bit hs;
        int w;
        int idx;
        #1;
        exp_rv = '0;
        if (owner >= 0 && age >= 2) exp_rv[owner] = 1'b1;
        hs = (exp_rv != '0) && rsp_ready[owner];
        w = -1;
        if (owner < 0 || hs) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        exp_rr = '0;
        if (w >= 0) exp_rr[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("grant_id", 32'(grant_id), (owner >= 0) ? 32'(owner) : 32'd0);
        if (exp_rv != '0) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_zero", 32'(rsp_zero), 32'(m_res == 32'd0));
        end
        if (owner >= 0 && age == 1) begin
            chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
            chk("alu_int1", alu_integer1, m_op1);
            chk("alu_int2", alu_integer2, m_op2);
        end else begin
            chk("alu_ctrl_idle", 32'(alu_ctrl), 32'hF);
            chk("alu_int1_idle", alu_integer1, 32'd0);
            chk("alu_int2_idle", alu_integer2, 32'd0);
        end
`ifdef ALU_ARB_STATS_EN
        exp_gc = {cnt[1][15:0], cnt[0][15:0]};
`else
        exp_gc = 32'd0;
`endif
        chk("grant_count", grant_count, exp_gc);
        if (req_ready != '0) dut_grants.push_back(req_ready[1] ? 1 : 0);
        @(posedge clk);
        if (hs) owner = -1;
        if (owner >= 0) age++;
        if (w >= 0) begin
            owner  = w;
            age    = 1;
            m_op1  = req_op1[w*32 +: 32];
            m_op2  = req_op2[w*32 +: 32];
            m_ctrl = req_ctrl[w*4 +: 4];
            m_res  = alu_f(m_op1, m_op2, m_ctrl);
            ptr    = (w + 1) % N;
            if (cnt[w] < 65535) cnt[w]++;
        end
        acc_w = w;
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        for (int k = 0; k < 6 && owner >= 0; k++) cycle();
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op1   = '0;
        req_op2   = '0;
        req_ctrl  = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();

        // Reset state
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("rst_grant_count", grant_count, 32'd0);
        cycle();

        // 5 - 3 on requester 0
        set_req(0, 32'd5, 32'd3, 4'b0001);
        cycle();
        clr_req(0);
        cycle();
        cycle();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'b01);
        chk("t1_result", rsp_result, 32'd2);
        chk("t1_zero", 32'(rsp_zero), 32'd0);
        rsp_ready = 2'b01;
        cycle();
        drain();

        // Both requesters continuously valid: alternating grants every 2 cycles
        dut_grants.delete();
        rsp_ready = 2'b11;
        set_req(0, $urandom, $urandom, 4'($urandom_range(0, 9)));
        set_req(1, $urandom, $urandom, 4'($urandom_range(0, 9)));
        for (int c = 0; c < 8; c++) begin
            if (acc_w >= 0) set_req(acc_w, $urandom, $urandom, 4'($urandom_range(0, 9)));
            cycle();
        end
        chk("t2_num_grants", 32'(dut_grants.size()), 32'd4);
        for (int k = 0; k < 4 && k < dut_grants.size(); k++)
            chk("t2_grant_order", 32'(dut_grants[k]), 32'((1 + k) % 2));
        drain();

        // SRA with a stalled response; non-owner rsp_ready ignored
        rsp_ready = 2'b00;
        set_req(1, 32'h80000000, 32'd4, 4'b1001);
        cycle();
        clr_req(1);
        set_req(0, 32'd11, 32'd22, 4'b0000);
        cycle();
        cycle();
        chk("t3_rsp_valid", 32'(rsp_valid), 32'b10);
        chk("t3_result", rsp_result, 32'hF8000000);
        rsp_ready = 2'b01;
        repeat (5) cycle();
        chk("t3_held_result", rsp_result, 32'hF8000000);
        chk("t3_held_ready", 32'(req_ready), 32'd0);
        rsp_ready = 2'b10;
        cycle();
        drain();

        // Zero result, and idle ALU drive
        chk("t4_idle_ctrl", 32'(alu_ctrl), 32'hF);
        chk("t4_idle_int1", alu_integer1, 32'd0);
        rsp_ready = 2'b00;
        set_req(0, 32'd7, 32'd7, 4'b0001);
        cycle();
        clr_req(0);
        cycle();
        cycle();
        chk("t4_result", rsp_result, 32'd0);
        chk("t4_zero", 32'(rsp_zero), 32'd1);
        drain();

        // Reset during RESP drops the operation and returns rr_ptr to 0
        rsp_ready = 2'b00;
        set_req(0, 32'd9, 32'd1, 4'b0000);
        cycle();
        clr_req(0);
        cycle();
        cycle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_grant_id", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        rsp_ready = 2'b11;
        cycle();
        chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
        set_req(0, 32'd1, 32'd2, 4'b0000);
        set_req(1, 32'd3, 32'd4, 4'b0000);
        cycle();
        drain();

        // Accept counters
        do_reset();
        rsp_ready = 2'b10;
        for (int n = 0; n < 3; n++) begin
            set_req(1, $urandom, $urandom, 4'($urandom_range(0, 15)));
            cycle();
            clr_req(1);
            cycle();
            cycle();
        end
        #1;
`ifdef ALU_ARB_STATS_EN
        chk("t6_count1", 32'(grant_count[31:16]), 32'd3);
`else
        chk("t6_count_off", grant_count, 32'd0);
`endif
        drain();

        // Randomized traffic; pending requests are held until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc_w == i) begin
                    logic [31:0] a;
                    a = $urandom;
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_op1[i*32 +: 32] = a;
                    req_op2[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? a : $urandom;
                    req_ctrl[i*4 +: 4]  = 4'($urandom_range(0, 15));
                end
            end
            rsp_ready = 2'($urandom);
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
